// File: rtl/frame_pkg.sv
// Shared frame geometry and reader state encoding for the 80x60 frame RAMs.
package frame_pkg;

    localparam int unsigned H_PIXELS    = 80;
    localparam int unsigned V_LINES     = 60;
    localparam int unsigned FRAME_WORDS = H_PIXELS * V_LINES;
    localparam int unsigned ADDR_W      = 14;
    localparam int unsigned DATA_W      = 9;
    localparam int unsigned X_W         = $clog2(H_PIXELS);
    localparam int unsigned Y_W         = $clog2(V_LINES);

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_STREAM = 2'd1,
        RD_LAST   = 2'd2
    } rd_state_e;

endpackage

// File: rtl/frame_xy_counter.sv
// Raster address generator: running linear address plus x/y position.
// The address wraps to 0 after the last frame word, never into unused RAM space.
module frame_xy_counter
    import frame_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] addr,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              last_w;

    assign last_w = (addr_q == ADDR_W'(FRAME_WORDS - 1));

    // Next position: clear wins over increment; the last word wraps everything to 0.
    always_comb begin
        addr_d = addr_q;
        x_d    = x_q;
        y_d    = y_q;
        if (clr || (inc && last_w)) begin
            addr_d = '0;
            x_d    = '0;
            y_d    = '0;
        end else if (inc) begin
            addr_d = addr_q + 1'b1;
            if (x_q == X_W'(H_PIXELS - 1)) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            addr_q <= addr_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

    assign addr = addr_q;
    assign x    = x_q;
    assign y    = y_q;
    assign last = last_w;

endmodule

// File: rtl/frame_ram_reader.sv
// Frame RAM read side: scans one frame in raster order and emits pixels on a
// valid/ready stream with sof/eol/eof markers and a frame_done pulse.
module frame_ram_reader
    import frame_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic [ADDR_W-1:0] addr_rd,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              frame_done
);

    rd_state_e         state_q, state_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sof_q, sof_d;
    logic              eol_q, eol_d;
    logic              eof_q, eof_d;
    logic              done_q, done_d;

    logic              cnt_inc, cnt_clr, cnt_last, ld;
    logic [X_W-1:0]    cnt_x;
    logic [Y_W-1:0]    cnt_y;

    frame_xy_counter u_xy (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (cnt_inc),
        .clr     (cnt_clr),
        .addr    (addr_rd),
        .x       (cnt_x),
        .y       (cnt_y),
        .last    (cnt_last)
    );

    // Output slot is free when empty or being drained this cycle.
    assign ld = !valid_q || out_ready;

    // Next-state and output-register logic.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        data_d  = data_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        eof_d   = eof_q;
        done_d  = 1'b0;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (start && !abort) begin
                    state_d = RD_STREAM;
                    busy_d  = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            RD_STREAM, RD_LAST: begin
                if (abort) begin
                    state_d = RD_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    sof_d   = 1'b0;
                    eol_d   = 1'b0;
                    eof_d   = 1'b0;
                    cnt_clr = 1'b1;
                end else if (state_q == RD_STREAM) begin
                    if (ld) begin
                        data_d  = ram_data;
                        valid_d = 1'b1;
                        sof_d   = (cnt_x == '0) && (cnt_y == '0);
                        eol_d   = (cnt_x == X_W'(H_PIXELS - 1));
                        eof_d   = cnt_last;
                        cnt_inc = 1'b1;
                        if (cnt_last) begin
                            state_d = RD_LAST;
                        end
                    end
                end else if (valid_q && out_ready) begin
                    state_d = RD_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    sof_d   = 1'b0;
                    eol_d   = 1'b0;
                    eof_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RD_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_sof    = sof_q;
    assign out_eol    = eol_q;
    assign out_eof    = eof_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_frame_ram_reader.sv
// Randomized self-checking bench for frame_ram_reader with a behavioural RAM.
module tb_frame_ram_reader;
    import frame_pkg::*;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic              busy;
    logic [ADDR_W-1:0] addr_rd;
    logic [DATA_W-1:0] ram_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_eol;
    logic              out_eof;
    logic              frame_done;

    frame_ram_reader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .addr_rd    (addr_rd),
        .ram_data   (ram_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, combinational read.
    logic [DATA_W-1:0] ram [FRAME_WORDS];
    logic              we;
    int                waddr;
    logic [DATA_W-1:0] wdata;

    always @(posedge clk) if (we) ram[waddr] <= wdata;

    always_comb begin
        int a;
        a = int'(addr_rd);
        ram_data = (a < int'(FRAME_WORDS)) ? ram[a] : '0;
    end

    // Reference image: what each beat of the next frame must carry.
    int model [FRAME_WORDS];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fd_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              s;
        logic              e;
        logic              f;
    } beat_t;

    beat_t q[$];

    bit                stall_en   = 0;
    bit                stall_prev = 0;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;

    // Stream monitor: capture accepted beats, check exclusivity and stall stability.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) q.push_back({out_data, out_sof, out_eol, out_eof});
            if (frame_done) begin
                fd_count++;
                check("done_valid_excl", int'(out_valid), 0);
            end
            if (stall_en && stall_prev && out_valid) begin
                check("stall_addr", int'(addr_rd), int'(st_addr));
                check("stall_data", int'(out_data), int'(st_data));
            end
            stall_prev = out_valid && !out_ready;
            st_addr    = addr_rd;
            st_data    = out_data;
        end else begin
            stall_prev = 0;
        end
    end

    task automatic check_reset_vals(input string name);
        check({name, "_busy"},  int'(busy), 0);
        check({name, "_valid"}, int'(out_valid), 0);
        check({name, "_addr"},  int'(addr_rd), 0);
        check({name, "_data"},  int'(out_data), 0);
        check({name, "_marks"}, int'({out_sof, out_eol, out_eof}), 0);
        check({name, "_done"},  int'(frame_done), 0);
    endtask

    // Compare captured beats against the reference image and raster rules.
    task automatic check_beats(input string name);
        int bad_d = 0, bad_s = 0, bad_e = 0, bad_f = 0;
        check({name, "_beats"}, q.size(), int'(FRAME_WORDS));
        for (int i = 0; i < q.size() && i < int'(FRAME_WORDS); i++) begin
            if (int'(q[i].d) != model[i]) bad_d++;
            if (q[i].s != (i == 0)) bad_s++;
            if (q[i].e != ((i % int'(H_PIXELS)) == int'(H_PIXELS) - 1)) bad_e++;
            if (q[i].f != (i == int'(FRAME_WORDS) - 1)) bad_f++;
        end
        check({name, "_data_bad"}, bad_d, 0);
        check({name, "_sof_bad"},  bad_s, 0);
        check({name, "_eol_bad"},  bad_e, 0);
        check({name, "_eof_bad"},  bad_f, 0);
    endtask

    // Issue start now and run one frame to frame_done; returns with frame_done high.
    task automatic run_frame(input string name, input int ready_pct, input bit extras, input bit wr5);
        int k_c = 0, fd_c = 0;
        bit seen = 0, wr_done = 0;
        q.delete();
        start = 1; out_ready = 1;
        @(posedge clk); #1;
        start = 0;
        k_c = cyc;
        check({name, "_busy_after_start"}, int'(busy), 1);
        check({name, "_valid_before_first"}, int'(out_valid), 0);
        for (int i = 0; i < 20000 && !seen; i++) begin
            out_ready = ($urandom_range(99) < ready_pct);
            start = extras && out_valid && (q.size() == 10 || out_eof);
            we = 0;
            if (wr5 && !wr_done && addr_rd == 5) begin
                we = 1; waddr = 5; wdata = 9'h1AA; wr_done = 1;
            end
            @(posedge clk); #1;
            if (i == 0) begin
                check({name, "_first_valid"}, int'(out_valid), 1);
                check({name, "_first_sof"}, int'(out_sof), 1);
                check({name, "_first_data"}, int'(out_data), model[0]);
            end
            if (frame_done) begin
                seen = 1; fd_c = cyc;
            end
        end
        start = 0; we = 0;
        check({name, "_done_seen"}, int'(seen), 1);
        if (ready_pct == 100) check({name, "_done_latency"}, fd_c - k_c, int'(FRAME_WORDS) + 1);
        check({name, "_busy_at_done"}, int'(busy), 0);
        check({name, "_addr_at_done"}, int'(addr_rd), 0);
        check_beats(name);
    endtask

    initial begin
        int fd0;
        bit hit;
        for (int i = 0; i < int'(FRAME_WORDS); i++) begin
            ram[i]   = DATA_W'(i);
            model[i] = i & 511;
        end
        reset_n = 1; start = 0; abort = 0; out_ready = 0; we = 0; waddr = 0; wdata = '0;
        #3 reset_n = 0;
        #2 check_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        repeat (2) @(posedge clk);
        #1 check_reset_vals("idle");

        // Full-rate frame, then a start issued while frame_done is high.
        run_frame("f_full", 100, 0, 0);
        run_frame("f_b2b", 100, 1, 0);
        repeat (6) @(posedge clk);
        #1;
        check("extra_start_busy", int'(busy), 0);
        check("extra_start_nobeats", q.size(), int'(FRAME_WORDS));

        // Random backpressure with hold checks.
        stall_en = 1;
        run_frame("f_rand", 50, 0, 0);
        @(posedge clk); #1;
        stall_en = 0;

        // Abort mid-frame.
        q.delete();
        fd0 = fd_count;
        start = 1; out_ready = 1;
        @(posedge clk); #1;
        start = 0;
        hit = 0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            if (q.size() == 2000 && out_valid) hit = 1;
            else begin @(posedge clk); #1; end
        end
        check("abort_reach_beat", int'(hit), 1);
        check("abort_pre_data", int'(out_data), model[2000]);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        check("abort_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_addr", int'(addr_rd), 0);
        repeat (5) @(posedge clk);
        #1 check("abort_no_done", fd_count - fd0, 0);
        start = 1; abort = 1;
        @(posedge clk); #1;
        start = 0; abort = 0;
        check("abort_start_idle_busy", int'(busy), 0);
        check("abort_start_idle_valid", int'(out_valid), 0);
        run_frame("f_after_abort", 50, 0, 0);
        @(posedge clk); #1;

        // Asynchronous reset mid-frame.
        q.delete();
        start = 1; out_ready = 1;
        @(posedge clk); #1;
        start = 0;
        hit = 0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            if (q.size() == 1234) hit = 1;
            else begin @(posedge clk); #1; end
        end
        check("reset_reach_beat", int'(hit), 1);
        fd0 = fd_count;
        #2 reset_n = 0;
        #1 check_reset_vals("midreset");
        @(posedge clk); #1;
        reset_n = 1;
        check("midreset_no_done", fd_count - fd0, 0);
        @(posedge clk); #1;
        run_frame("f_after_reset", 100, 0, 0);

        // Write colliding with the read of address 5: old word, then new word next frame.
        run_frame("f_wr_collide", 100, 0, 1);
        model[5] = 9'h1AA;
        run_frame("f_wr_next", 100, 0, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
